// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder: a chain of WIDTH full-adder cells feeding
// the sum/carry-out flops. Operands and sum are indexed [WIDTH:1], bit 1 LSB.

// Single-bit full-adder cell; the carry out is written in generate/propagate
// form so the ripple path is easy to follow in a netlist or waveform.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

module four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:1]   a,
  input  logic [WIDTH:1]   b,
  input  logic             cin,
  output logic [WIDTH:1]   sum,
  output logic             cout
);

  // carry[i] is the carry into cell i; carry[WIDTH+1] is the final carry-out.
  logic [WIDTH+1:1] carry;
  logic [WIDTH:1]   sum_d;
  logic             cout_d;
  logic [WIDTH:1]   sum_q;
  logic             cout_q;

  assign carry[1] = cin;

  // Ripple chain: each cell consumes the previous cell's carry.
  for (genvar i = 1; i <= WIDTH; i++) begin : g_cell
    fa_cell u_fa (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (carry[i]),
      .s_o (sum_d[i]),
      .c_o (carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH+1];

  // Output registers: synchronous reset has priority, otherwise load every edge.
  // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_four_bit_adder.sv
// Directed self-checking bench for the registered 4-bit ripple-carry adder.
module tb_four_bit_adder;

  logic       clk;
  logic       rst;
  logic [4:1] a;
  logic [4:1] b;
  logic       cin;
  logic [4:1] sum;
  logic       cout;

  int errors;
  int checks;

  four_bit_adder #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, take one rising edge, settle 1 time unit.
  task automatic step(input logic [4:1] av, input logic [4:1] bv,
                      input logic cv, input logic rv);
    @(negedge clk);
    a   = av;
    b   = bv;
    cin = cv;
    rst = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(4'd9, 4'd9, 1'b1, 1'b1);
    checks++;
    if ({cout, sum} !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold: got cout=%b sum=%0d, want cout=0 sum=0", cout, sum);
    end
    step(4'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if ({cout, sum} !== 5'd0) begin
      errors++;
      $display("FAIL reset_zero_add: got cout=%b sum=%0d, want cout=0 sum=0", cout, sum);
    end
  endtask

  task automatic test_carry_in_latency();
    @(negedge clk);
    a   = 4'hA;
    b   = 4'd0;
    cin = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if ({cout, sum} !== 5'd0) begin
      errors++;
      $display("FAIL latency_before_edge: got cout=%b sum=%0d, want cout=0 sum=0", cout, sum);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cout, sum} !== {1'b0, 4'd11}) begin
      errors++;
      $display("FAIL latency_after_edge: got cout=%b sum=%0d, want cout=0 sum=11", cout, sum);
    end
  endtask

  task automatic test_single_operand();
    logic [4:1] av [7];
    logic [4:1] bv [7];
    logic       cv [7];
    logic [4:1] sv [7];
    av = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
    bv = '{4'd8, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0};
    cv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sv = '{4'd8, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd0};
    for (int i = 0; i < 7; i++) begin
      step(av[i], bv[i], cv[i], 1'b0);
      checks++;
      if ({cout, sum} !== {1'b0, sv[i]}) begin
        errors++;
        $display("FAIL single_operand[%0d] a=%0d b=%0d cin=%b: got cout=%b sum=%0d, want cout=0 sum=%0d",
                 i, av[i], bv[i], cv[i], cout, sum, sv[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [4:1] av [3];
    logic [4:1] bv [3];
    logic       cv [3];
    logic [4:1] sv [3];
    av = '{4'd15, 4'd15, 4'd8};
    bv = '{4'd1,  4'd15, 4'd8};
    cv = '{1'b0,  1'b1,  1'b0};
    sv = '{4'd0,  4'd15, 4'd0};
    for (int i = 0; i < 3; i++) begin
      step(av[i], bv[i], cv[i], 1'b0);
      checks++;
      if ({cout, sum} !== {1'b1, sv[i]}) begin
        errors++;
        $display("FAIL wrap[%0d] a=%0d b=%0d cin=%b: got cout=%b sum=%0d, want cout=1 sum=%0d",
                 i, av[i], bv[i], cv[i], cout, sum, sv[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(4'd5, 4'd6, 1'b0, 1'b0);
    checks++;
    if ({cout, sum} !== {1'b0, 4'd11}) begin
      errors++;
      $display("FAIL midstream_pre: got cout=%b sum=%0d, want cout=0 sum=11", cout, sum);
    end
    step(4'd15, 4'd15, 1'b1, 1'b1);
    checks++;
    if ({cout, sum} !== 5'd0) begin
      errors++;
      $display("FAIL midstream_reset: got cout=%b sum=%0d, want cout=0 sum=0", cout, sum);
    end
    step(4'd15, 4'd15, 1'b1, 1'b0);
    checks++;
    if ({cout, sum} !== {1'b1, 4'd15}) begin
      errors++;
      $display("FAIL midstream_release: got cout=%b sum=%0d, want cout=1 sum=15", cout, sum);
    end
  endtask

  task automatic test_exhaustive();
    logic [4:1] av;
    logic [4:1] bv;
    logic       cv;
    logic [4:0] expv;
    int         local_err;
    local_err = 0;
    for (int i = 0; i < 512; i++) begin
      av   = i[3:0];
      bv   = i[7:4];
      cv   = i[8];
      expv = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
      step(av, bv, cv, 1'b0);
      checks++;
      if ({cout, sum} !== expv) begin
        errors++;
        local_err++;
        if (local_err <= 10)
          $display("FAIL exhaustive a=%0d b=%0d cin=%b: got cout=%b sum=%0d, want cout=%b sum=%0d",
                   av, bv, cv, cout, sum, expv[4], expv[3:0]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    a      = '0;
    b      = '0;
    cin    = 1'b0;

    test_reset();
    test_carry_in_latency();
    test_single_operand();
    test_wrap();
    test_reset_midstream();
    test_exhaustive();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/four_bit_adder.md
Name:
four_bit_adder

Overview:
- Registered 4-bit ripple-carry adder.
- Adds two 4-bit operands and a carry-in, then registers the 4-bit sum and carry-out on the rising clock edge.
- Built as a chain of single-bit full-adder cells, so the carry path is explicit and easy to inspect.
- Used as a leaf arithmetic block inside larger datapaths; no handshake.

Parameters:
- WIDTH, 4, operand and sum width in bits; a ripple chain of WIDTH full-adder cells.
- Only 4 is required to be verified.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A, indexed [WIDTH:1]; bit 1 is the LSB.
- b  input  WIDTH  operand B, indexed [WIDTH:1]; bit 1 is the LSB.
- cin  input  1  carry-in into bit 1.
- sum  output  WIDTH  registered sum, indexed [WIDTH:1].
- cout  output  1  registered carry-out from bit WIDTH.

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-high.
- Arithmetic: {cout, sum} = a + b + cin, taken modulo 2^(WIDTH+1).
  - Unsigned; no overflow flag.
  - Full 5-bit result is always representable.
- Structure:
  - Cell i computes s_i = a_i ^ b_i ^ c_i and c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - c_1 = cin; cout = c_(WIDTH+1).
  - Combinational ripple chain feeds the output registers.
- Latency: 1 cycle. Inputs sampled at rising edge N; sum/cout reflect them after edge N, stable until edge N+1.
- No enable: a new result is registered on every clock edge.
- Reset:
  - At any rising edge where rst=1: sum=0, cout=0, regardless of a/b/cin.
  - Reset has priority over the addition.
  - First edge with rst=0 loads the current a+b+cin.
  - Asserting rst mid-stream discards the in-flight result; no asynchronous path.
- Before the first reset or clocked load, output values are undefined.
- Unknown (X/Z) inputs give unknown outputs on the affected and downstream bits; no X masking or substitution.
- Wrap-around:
  - a=15, b=1, cin=0 gives sum=0, cout=1.
  - The maximum a=15, b=15, cin=1 gives sum=15, cout=1.
- Outputs are glitch-free: driven only from flops.

Test Plan:
- Reset then zeros: rst=1 for one edge with a=9, b=9, cin=1 → sum=0, cout=0. Then rst=0 with a=0, b=0, cin=0 → sum=0, cout=0.
- Directed carry-in and latency: a=0xA, b=0, cin=1 → sum=11, cout=0 after the next edge, not before.
- Single-operand and carry chain:
  - a=0, b=8, cin=0 → sum=8.
  - a=1, b=0, cin=0 → sum=1.
  - a=0, b=1, cin=1 → sum=2.
  - a=1, b=1, cin=0 → sum=2.
  - a=1, b=0, cin=1 → sum=2.
  - a=1, b=1, cin=1 → sum=3.
  - cout=0 in all of these cases.
- Wrap/overflow:
  - a=15, b=1, cin=0 → sum=0, cout=1.
  - a=15, b=15, cin=1 → sum=15, cout=1.
  - a=8, b=8, cin=0 → sum=0, cout=1.
- Reset mid-stream: apply a=15, b=15, cin=1 with rst=1 → sum=0, cout=0 on that edge. Release rst → sum=15, cout=1 on the following edge.
- Exhaustive self-check: all 512 combinations of a, b, cin, one per cycle → each registered {cout,sum} equals a+b+cin one cycle later.
